// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS datapath.
// Holds the opcode and funct encodings, the control-field enums used to
// decode the controller strobes, and the immediate sign-extension helper.
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32x32 register file, two combinational read ports and one
// synchronous write port. $0 is hard-wired to zero. A read of the register
// being written in the same cycle returns the old contents (no bypass).
// Ports:
//   clk, reset        clock (rising edge), async active-high clear of all regs
//   we, wa, wd        write enable, address, data
//   ra1/rd1, ra2/rd2  read address/data pairs
module mc_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_r [32];

  // Storage: async clear, write port discards writes to $0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs_r[wa] <= wd;
    end
  end

  // Reads of $0 are forced to zero independently of the storage contents
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_r[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_r[ra2];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS datapath (lw, sw, add/sub/and/or/slt, beq,
// addi, j). The controller FSM drives the per-cycle strobes; this block holds
// PC, IR, MDR, A, B, ALUOut and the register file and drives the unified
// memory address and write data.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   pcwrite, branch       PC load enables (branch qualified by zero)
//   irwrite, regwrite     IR load / register file write enables
//   alusrca, iord         srcA select (PC/A), memory address select (PC/ALUOut)
//   memtoreg, regdst      write-back data (ALUOut/MDR), dest (rt/rd)
//   alusrcb, pcsrc        srcB select, next-PC select
//   alucontrol            ALU operation
//   readdata              memory read data
//   adr, writedata        memory address, write data (B register)
//   op, funct, zero       decode fields and ALU zero flag for the controller
module mc_datapath
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero
);

  logic [WIDTH-1:0] pc_r, ir_r, mdr_r, a_r, b_r, aluout_r;
  logic [WIDTH-1:0] rd1_s, rd2_s, wd_s, signimm_s;
  logic [WIDTH-1:0] srca_s, srcb_s, aluresult_s, pcnext_s;
  logic [4:0]       wa_s;
  logic             pcen_s;

  assign signimm_s = sign_ext16(ir_r[15:0]);
  assign wa_s      = regdst ? ir_r[15:11] : ir_r[20:16];
  assign wd_s      = memtoreg ? mdr_r : aluout_r;
  assign srca_s    = alusrca ? a_r : pc_r;
  assign adr       = iord ? aluout_r : pc_r;
  assign writedata = b_r;
  assign op        = ir_r[31:26];
  assign funct     = ir_r[5:0];
  assign zero      = (aluresult_s == 32'd0);
  // Both enables high simply load the PC
  assign pcen_s    = pcwrite | (branch & zero);

  mc_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .wa    (wa_s),
    .wd    (wd_s),
    .ra1   (ir_r[25:21]),
    .ra2   (ir_r[20:16]),
    .rd1   (rd1_s),
    .rd2   (rd2_s)
  );

  // ALU source B select
  always_comb begin
    srcb_s = 32'd0;
    case (alusrcb_t'(alusrcb))
      SRCB_B:     srcb_s = b_r;
      SRCB_FOUR:  srcb_s = 32'd4;
      SRCB_IMM:   srcb_s = signimm_s;
      SRCB_IMMSH: srcb_s = {signimm_s[29:0], 2'b00};
      default:    srcb_s = 32'd0;
    endcase
  end

  // ALU: modulo-2^32 arithmetic, signed slt, unused codes yield zero
  always_comb begin
    aluresult_s = 32'd0;
    case (alu_ctl_t'(alucontrol))
      ALU_AND: aluresult_s = srca_s & srcb_s;
      ALU_OR:  aluresult_s = srca_s | srcb_s;
      ALU_ADD: aluresult_s = srca_s + srcb_s;
      ALU_SUB: aluresult_s = srca_s - srcb_s;
      ALU_SLT: aluresult_s = {31'd0, ($signed(srca_s) < $signed(srcb_s))};
      default: aluresult_s = 32'd0;
    endcase
  end

  // Next-PC select; jump target uses the PC already incremented at fetch
  always_comb begin
    pcnext_s = pc_r;
    case (pcsrc_t'(pcsrc))
      PCSRC_ALU:    pcnext_s = aluresult_s;
      PCSRC_ALUOUT: pcnext_s = aluout_r;
      PCSRC_JUMP:   pcnext_s = {pc_r[31:28], ir_r[25:0], 2'b00};
      PCSRC_HOLD:   pcnext_s = pc_r;
      default:      pcnext_s = pc_r;
    endcase
  end

  // Program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (pcen_s) begin
      pc_r <= pcnext_s;
    end
  end

  // Instruction register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r <= 32'd0;
    end else if (irwrite) begin
      ir_r <= readdata;
    end
  end

  // Non-architectural pipeline registers, loaded every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr_r    <= 32'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      aluout_r <= 32'd0;
    end else begin
      mdr_r    <= readdata;
      a_r      <= rd1_s;
      b_r      <= rd2_s;
      aluout_r <= aluresult_s;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed-vector bench for mc_datapath. The bench plays the
// controller and the memory, stepping the datapath through instruction
// sequences and comparing outputs against hand-computed values.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, branch, irwrite, regwrite;
  logic        alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [31:0] adr, writedata;
  logic [5:0]  op, funct;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  mc_datapath #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .readdata   (readdata),
    .adr        (adr),
    .writedata  (writedata),
    .op         (op),
    .funct      (funct),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    pcwrite = 1'b0; branch = 1'b0; irwrite = 1'b0; regwrite = 1'b0;
    alusrca = 1'b0; iord = 1'b0; memtoreg = 1'b0; regdst = 1'b0;
    alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // FETCH: IR <= instr, PC <= PC + 4
  task automatic fetch(input logic [31:0] instr);
    clr_ctl();
    irwrite = 1'b1; alusrcb = 2'b01; alucontrol = 3'b010; pcwrite = 1'b1;
    readdata = instr;
    tick();
    clr_ctl();
    readdata = 32'd0;
  endtask

  // DECODE: A/B from register file, ALUOut <= PC + (signimm << 2)
  task automatic decode();
    clr_ctl();
    alusrcb = 2'b11; alucontrol = 3'b010;
    tick();
    clr_ctl();
  endtask

  // Address calc (MEMADR / ADDIEX): ALUOut <= A + signimm
  task automatic addr_ex();
    clr_ctl();
    alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010;
    tick();
    clr_ctl();
  endtask

  // ADDIWB: rt <= ALUOut
  task automatic addi_wb();
    clr_ctl();
    regwrite = 1'b1;
    tick();
    clr_ctl();
  endtask

  // RTYPEEX with slt, then RTYPEWB to rd
  task automatic slt_ex_wb();
    clr_ctl();
    alusrca = 1'b1; alucontrol = 3'b111;
    tick();
    clr_ctl();
    regwrite = 1'b1; regdst = 1'b1;
    tick();
    clr_ctl();
  endtask

  logic [2:0] alu_codes [8];
  logic       alu_zero_exp [8];

  initial begin
    // A = 0x80000000, B = 1: add/or/sub/slt non-zero; and and undefined codes give 0
    alu_codes[0] = 3'b010; alu_zero_exp[0] = 1'b0;
    alu_codes[1] = 3'b000; alu_zero_exp[1] = 1'b1;
    alu_codes[2] = 3'b001; alu_zero_exp[2] = 1'b0;
    alu_codes[3] = 3'b110; alu_zero_exp[3] = 1'b0;
    alu_codes[4] = 3'b111; alu_zero_exp[4] = 1'b0;
    alu_codes[5] = 3'b011; alu_zero_exp[5] = 1'b1;
    alu_codes[6] = 3'b100; alu_zero_exp[6] = 1'b1;
    alu_codes[7] = 3'b101; alu_zero_exp[7] = 1'b1;

    // 1. Reset
    clr_ctl();
    readdata = 32'd0;
    reset = 1'b1;
    #3;
    check_val("rst_adr", adr, 32'h0);
    check_val("rst_op", {26'd0, op}, 32'h0);
    check_val("rst_funct", {26'd0, funct}, 32'h0);
    check_val("rst_wdata", writedata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick(); tick();
    check_val("idle_pc", adr, 32'h0);

    // 2. Fetch addi $t0,$0,5
    fetch(32'h2008_0005);
    check_val("fetch_adr", adr, 32'h4);
    check_val("fetch_op", {26'd0, op}, 32'h08);
    check_val("fetch_funct", {26'd0, funct}, 32'h05);

    // 3. addi then sw $t0,0($0)
    decode();
    addr_ex();
    addi_wb();
    fetch(32'hAC08_0000);
    check_val("sw_op", {26'd0, op}, 32'h2B);
    decode();
    check_val("sw_wdata_dec", writedata, 32'h5);
    addr_ex();
    iord = 1'b1;
    #1;
    check_val("memwr_adr", adr, 32'h0);
    check_val("memwr_wdata", writedata, 32'h5);
    tick();
    clr_ctl();
    #1;
    check_val("memwr_pc", adr, 32'h8);

    // 4. beq $8,$8,3 at PC=8 -> target 12+12=24
    fetch(32'h1108_0003);
    decode();
    alusrca = 1'b1; alucontrol = 3'b110; branch = 1'b1; pcsrc = 2'b01;
    #1;
    check_val("beq_eq_zero", {31'd0, zero}, 32'h1);
    tick();
    clr_ctl();
    #1;
    check_val("beq_taken_pc", adr, 32'd24);
    // beq $8,$0,3 at PC=24 -> not taken, PC stays 28
    fetch(32'h1100_0003);
    decode();
    alusrca = 1'b1; alucontrol = 3'b110; branch = 1'b1; pcsrc = 2'b01;
    #1;
    check_val("beq_ne_zero", {31'd0, zero}, 32'h0);
    tick();
    clr_ctl();
    #1;
    check_val("beq_nt_pc", adr, 32'd28);

    // PC wrap: beq $0,$0,-2 at PC 0 -> 0xFFFFFFFC with pcwrite and branch both high
    reset = 1'b1;
    #1;
    check_val("rst2_adr", adr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    fetch(32'h1000_FFFE);
    check_val("wrap_op", {26'd0, op}, 32'h04);
    decode();
    alusrca = 1'b1; alucontrol = 3'b110; branch = 1'b1; pcwrite = 1'b1; pcsrc = 2'b01;
    tick();
    clr_ctl();
    #1;
    check_val("wrap_pc_top", adr, 32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    check_val("wrap_pc_zero", adr, 32'h0);

    // 5. j 0x0100010 fetched at 0, executed at PC=4
    fetch(32'h0810_0010);
    check_val("j_op", {26'd0, op}, 32'h02);
    check_val("j_pc4", adr, 32'h4);
    pcsrc = 2'b10; pcwrite = 1'b1;
    tick();
    clr_ctl();
    #1;
    check_val("j_target", adr, 32'h0040_0040);

    // 6. lw $10,0($0) loading 0x80000000
    fetch(32'h8C0A_0000);
    decode();
    addr_ex();
    iord = 1'b1;
    readdata = 32'h8000_0000;
    #1;
    check_val("lw_adr", adr, 32'h0);
    tick();
    clr_ctl();
    readdata = 32'd0;
    regwrite = 1'b1; memtoreg = 1'b1;
    tick();
    clr_ctl();
    // addi $11,$0,1
    fetch(32'h200B_0001);
    decode();
    addr_ex();
    addi_wb();
    // slt $0,$10,$11 with ALU op sweep on A=0x80000000, B=1
    fetch(32'h014B_002A);
    check_val("slt_funct", {26'd0, funct}, 32'h2A);
    decode();
    alusrca = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alucontrol = alu_codes[i];
      #1;
      check_val($sformatf("alu_zero_%0d", i), {31'd0, zero}, {31'd0, alu_zero_exp[i]});
    end
    clr_ctl();
    slt_ex_wb();
    fetch(32'hAC00_0000);
    decode();
    check_val("r0_reads_zero", writedata, 32'h0);
    // slt $9,$10,$11 then sw $9
    fetch(32'h014B_482A);
    decode();
    slt_ex_wb();
    fetch(32'hAC09_0000);
    decode();
    check_val("slt_signed_r9", writedata, 32'h1);
    check_val("pc_after_sw9", adr, 32'h0040_0058);

    // Reset asserted during RTYPEWB of slt $9 (after clearing it via reset)
    fetch(32'h014B_482A);
    decode();
    clr_ctl();
    alusrca = 1'b1; alucontrol = 3'b111;
    tick();
    clr_ctl();
    regwrite = 1'b1; regdst = 1'b1;
    #1;
    check_val("wb_pc_before_rst", adr, 32'h0040_005C);
    reset = 1'b1;
    #1;
    check_val("midrst_adr", adr, 32'h0);
    check_val("midrst_wdata", writedata, 32'h0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    clr_ctl();
    fetch(32'hAC09_0000);
    decode();
    check_val("r9_after_rst", writedata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
